// File: rtl/shader_spi_loader.sv
// Host-side SPI mode-0 master that loads the shader's program/config port from a byte stream.
// Every output is registered. Each byte read back on MISO is returned on rx_* after its 8th rising SCLK edge.
module shader_spi_loader #(
  parameter int CLK_DIV = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tx_valid,
  output logic       tx_ready,
  input  logic [7:0] tx_data,
  input  logic       tx_last,
  output logic       rx_valid,
  output logic [7:0] rx_data,
  output logic       busy,
  output logic       spi_cs,
  output logic       spi_sclk,
  output logic       spi_mosi,
  input  logic       spi_miso
);

  localparam int CW = $clog2(CLK_DIV + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(CLK_DIV - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_LEAD, S_HIGH, S_LOW, S_NEXT, S_TRAIL, S_GAP
  } state_t;

  state_t          r_state, w_state_next;
  logic [CW-1:0]   r_cnt, w_cnt_next;
  logic [2:0]      r_bit, w_bit_next;
  logic [6:0]      r_tx_sh, w_tx_sh_next;
  logic [7:0]      r_rx_sh, w_rx_sh_next;
  logic            r_last, w_last_next;
  logic            r_cs, w_cs_next;
  logic            r_sclk, w_sclk_next;
  logic            r_mosi, w_mosi_next;
  logic            r_rx_valid, w_rx_valid_next;
  logic [7:0]      r_rx_data, w_rx_data_next;
  logic            r_tx_ready;
  logic            r_busy;
  logic            w_accept;
  logic            w_cnt_end;

  assign w_accept  = tx_valid && r_tx_ready;
  assign w_cnt_end = (r_cnt == CNT_MAX);

  always_comb begin
    w_state_next    = r_state;
    w_cnt_next      = '0;
    w_bit_next      = r_bit;
    w_tx_sh_next    = r_tx_sh;
    w_rx_sh_next    = r_rx_sh;
    w_last_next     = r_last;
    w_cs_next       = r_cs;
    w_sclk_next     = r_sclk;
    w_mosi_next     = r_mosi;
    w_rx_valid_next = 1'b0;
    w_rx_data_next  = r_rx_data;

    unique case (r_state)
      S_IDLE, S_NEXT: begin
        w_sclk_next = 1'b0;
        if (r_state == S_IDLE) begin
          w_cs_next   = 1'b1;
          w_mosi_next = 1'b0;
        end
        if (w_accept) begin
          w_cs_next    = 1'b0;
          w_mosi_next  = tx_data[7];
          w_tx_sh_next = tx_data[6:0];
          w_last_next  = tx_last;
          w_bit_next   = 3'd0;
          w_state_next = S_LEAD;
        end
      end
      S_LEAD, S_LOW: begin
        w_cnt_next = w_cnt_end ? '0 : r_cnt + CW'(1);
        if (w_cnt_end) begin
          // rising edge: MISO is captured on the same clk edge that raises SCLK
          w_sclk_next  = 1'b1;
          w_rx_sh_next = {r_rx_sh[6:0], spi_miso};
          w_state_next = S_HIGH;
        end
      end
      S_HIGH: begin
        w_cnt_next = w_cnt_end ? '0 : r_cnt + CW'(1);
        if (w_cnt_end) begin
          w_sclk_next = 1'b0;
          if (r_bit == 3'd7) begin
            w_rx_data_next  = r_rx_sh;
            w_rx_valid_next = 1'b1;
            w_state_next    = r_last ? S_TRAIL : S_NEXT;
          end else begin
            w_bit_next   = r_bit + 3'd1;
            w_mosi_next  = r_tx_sh[6];
            w_tx_sh_next = {r_tx_sh[5:0], 1'b0};
            w_state_next = S_LOW;
          end
        end
      end
      S_TRAIL: begin
        w_cnt_next = w_cnt_end ? '0 : r_cnt + CW'(1);
        if (w_cnt_end) begin
          w_cs_next    = 1'b1;
          w_state_next = S_GAP;
        end
      end
      S_GAP: begin
        w_cnt_next = w_cnt_end ? '0 : r_cnt + CW'(1);
        if (w_cnt_end) w_state_next = S_IDLE;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_bit      <= 3'd0;
      r_tx_sh    <= '0;
      r_rx_sh    <= '0;
      r_last     <= 1'b0;
      r_cs       <= 1'b1;
      r_sclk     <= 1'b0;
      r_mosi     <= 1'b0;
      r_rx_valid <= 1'b0;
      r_rx_data  <= '0;
      r_tx_ready <= 1'b0;
      r_busy     <= 1'b0;
    end else begin
      r_state    <= w_state_next;
      r_cnt      <= w_cnt_next;
      r_bit      <= w_bit_next;
      r_tx_sh    <= w_tx_sh_next;
      r_rx_sh    <= w_rx_sh_next;
      r_last     <= w_last_next;
      r_cs       <= w_cs_next;
      r_sclk     <= w_sclk_next;
      r_mosi     <= w_mosi_next;
      r_rx_valid <= w_rx_valid_next;
      r_rx_data  <= w_rx_data_next;
      // ready/busy are registered from the next state so they line up with it
      r_tx_ready <= (w_state_next == S_IDLE) || (w_state_next == S_NEXT);
      r_busy     <= (w_state_next != S_IDLE);
    end
  end

  assign tx_ready = r_tx_ready;
  assign rx_valid = r_rx_valid;
  assign rx_data  = r_rx_data;
  assign busy     = r_busy;
  assign spi_cs   = r_cs;
  assign spi_sclk = r_sclk;
  assign spi_mosi = r_mosi;

endmodule
